fp_loo_sched: RTL

Issue scheduler for the shared single-cycle FP conversion unit (ITOF, FTOI, TRUNC). Arbitrates up to NREQ issue ports round-robin and registers the winning operation onto the unit. Tracks each operation's tag through the unit's fixed latency and buffers results in a small output FIFO with valid/ready backpressure. Credit-based issue guarantees no result is ever dropped.

---
 rtl/fp_loo_sched.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fp_loo_sched.sv
// fp_loo_sched: round-robin issue scheduler for the shared FP conversion unit.
// Tags ride a LAT-deep pipe; results land in a credit-protected output FIFO.
module fp_loo_sched #(
  parameter int FPWID      = 52,
  parameter int NREQ       = 4,
  parameter int TAGW       = 6,
  parameter int LAT        = 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [3*NREQ-1:0]      req_rm,
  input  logic [FPWID*NREQ-1:0]  req_a,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  output logic [NREQ-1:0]        gnt,
  output logic                   unit_issue,
  output logic [1:0]             unit_op,
  output logic [2:0]             unit_rm,
  output logic [FPWID-1:0]       unit_a,
  input  logic [FPWID-1:0]       unit_o,
  input  logic                   unit_done,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [FPWID-1:0]       res_data,
  output logic [TAGW-1:0]        res_tag,
  input  logic                   flush,
  output logic                   err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int CW = $clog2(OBUF_DEPTH + 1);
  localparam int SW = $clog2(OBUF_DEPTH + LAT + 2);

  typedef struct packed {
    logic [1:0]       op;
    logic [2:0]       rm;
    logic [FPWID-1:0] a;
    logic [TAGW-1:0]  tag;
  } iss_t;

  iss_t            req_s [NREQ];
  logic [NREQ-1:0] legal;
  logic [NREQ-1:0] illegal;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign req_s[i] = '{
      op:  req_op[2*i +: 2],
      rm:  req_rm[3*i +: 3],
      a:   req_a[FPWID*i +: FPWID],
      tag: req_tag[TAGW*i +: TAGW]
    };
    assign legal[i]   = req[i] && (req_op[2*i +: 2] != 2'd3);
    assign illegal[i] = req[i] && (req_op[2*i +: 2] == 2'd3);
  end

  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     sel;
  logic [IW-1:0]     cidx;
  int                cand;
  logic              found;
  logic              allow;
  logic              grant;

  logic              iss_v;
  iss_t              iss_q;
  logic [LAT-1:0]    pipe_v;
  logic [TAGW-1:0]   pipe_tag [LAT];

  logic [FPWID-1:0]  mem_d [OBUF_DEPTH];
  logic [TAGW-1:0]   mem_t [OBUF_DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     used;
  logic              push;
  logic              pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover everything between the issue register and the FIFO.
  always_comb begin
    used = SW'(cnt) + SW'(iss_v);
    for (int k = 0; k < LAT; k++) begin
      used = used + SW'(pipe_v[k]);
    end
  end

  assign allow = used < SW'(OBUF_DEPTH);

  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    cidx  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NREQ) begin
        cand = cand - NREQ;
      end
      cidx = cand[IW-1:0];
      if (!found && legal[cidx]) begin
        found = 1'b1;
        sel   = cidx;
      end
    end
  end

  assign grant = found && allow && !flush;
  assign gnt   = grant ? (NREQ'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_v  <= 1'b0;
      iss_q  <= '0;
      rr_ptr <= IW'(NREQ - 1);
    end else begin
      iss_v <= grant;
      if (grant) begin
        iss_q  <= req_s[sel];
        rr_ptr <= sel;
      end
    end
  end

  assign unit_issue = iss_v;
  assign unit_op    = iss_q.op;
  assign unit_rm    = iss_q.rm;
  assign unit_a     = iss_q.a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      for (int k = 0; k < LAT; k++) begin
        pipe_tag[k] <= '0;
      end
    end else begin
      pipe_v[0]   <= iss_v && !flush;
      pipe_tag[0] <= iss_q.tag;
      for (int k = 1; k < LAT; k++) begin
        pipe_v[k]   <= pipe_v[k-1] && !flush;
        pipe_tag[k] <= pipe_tag[k-1];
      end
    end
  end

  assign push      = pipe_v[LAT-1] && !flush;
  assign res_valid = cnt != '0;
  assign pop       = res_valid && res_ready;
  assign res_data  = mem_d[rd_ptr];
  assign res_tag   = mem_t[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < OBUF_DEPTH; k++) begin
        mem_d[k] <= '0;
        mem_t[k] <= '0;
      end
    end else if (push) begin
      mem_d[wr_ptr] <= unit_o;
      mem_t[wr_ptr] <= pipe_tag[LAT-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= nxt(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + CW'(1);
      end else if (pop && !push) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((|illegal) || (unit_done != pipe_v[LAT-1])) begin
      err <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(push && cnt == CW'(OBUF_DEPTH)));
    end
  end

endmodule
